// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit pipelined CPU: datapath widths, the
// default halt encoding and the fetch-stage state encoding.
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;

  localparam logic [INSTR_W-1:0] HALT_OP_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Sequential PC step; the 8-bit add wraps 8'hFF to 8'h00 on purpose.
  function automatic logic [PC_W-1:0] pc_step(input logic [PC_W-1:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] count
);

  // Count enabled events, holding once the maximum is reached.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 16'h0000;
    end else if (enable && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: drives the PC update, owns the IF/ID register,
// detects halt and keeps stall/redirect statistics.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] HALT_OP     = HALT_OP_DEFAULT,
  parameter int                 BOOT_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic [PC_W-1:0]    newpc_o,
  output logic               pc_wenable_o,
  output logic               flush_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  output logic               instr_valid_o,
  output logic               halted_o,
  output logic [15:0]        stall_count_o,
  output logic [15:0]        squash_count_o
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  fetch_state_t       state, next_state;
  logic [3:0]         boot_count, next_boot_count;
  logic [INSTR_W-1:0] next_instr;
  logic [PC_W-1:0]    next_instr_pc;
  logic               next_valid;
  logic               next_halted;
  logic               wen;
  logic               redirect;
  logic [PC_W-1:0]    target;
  logic               stall_event;
  logic               squash_event;

  // Next-state, IF/ID update and PC-control decode for the current cycle.
  always_comb begin
    next_state      = state;
    next_boot_count = boot_count;
    next_instr      = instr_o;
    next_instr_pc   = instr_pc_o;
    next_valid      = instr_valid_o;
    next_halted     = halted_o;
    wen             = 1'b0;
    redirect        = 1'b0;
    target          = pc_i;
    stall_event     = 1'b0;
    squash_event    = 1'b0;
    case (state)
      BOOT: begin
        next_valid = 1'b0;
        if (boot_count == BOOT_LAST) begin
          next_state      = RUN;
          next_boot_count = 4'd0;
        end else begin
          next_boot_count = boot_count + 4'd1;
        end
      end
      RUN: begin
        if (branch_taken_i) begin
          wen          = 1'b1;
          redirect     = 1'b1;
          target       = branch_target_i;
          next_valid   = 1'b0;
          squash_event = 1'b1;
        end else if (stall_i) begin
          stall_event = 1'b1;
        end else begin
          next_instr    = instr_i;
          next_instr_pc = pc_i;
          next_valid    = 1'b1;
          if (instr_i == HALT_OP) begin
            next_state  = HALT;
            next_halted = 1'b1;
          end else begin
            wen    = 1'b1;
            target = pc_step(pc_i);
          end
        end
      end
      HALT: begin
        if (branch_taken_i) begin
          // An older branch resolving after the halt restarts fetch.
          wen          = 1'b1;
          redirect     = 1'b1;
          target       = branch_target_i;
          next_valid   = 1'b0;
          squash_event = 1'b1;
          next_state   = RUN;
          next_halted  = 1'b0;
        end else if (stall_i) begin
          next_valid = instr_valid_o;
        end else begin
          next_valid = 1'b0;
        end
      end
      default: begin
        next_state      = BOOT;
        next_boot_count = 4'd0;
      end
    endcase
  end

  // PC-facing outputs, forced quiet while reset is asserted.
  always_comb begin
    if (reset_i) begin
      pc_wenable_o = 1'b0;
      newpc_o      = 8'h00;
      flush_o      = 1'b0;
    end else begin
      pc_wenable_o = wen;
      newpc_o      = wen ? target : pc_i;
      flush_o      = redirect;
    end
  end

  // State, boot timer, IF/ID register and halt flag.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      state         <= BOOT;
      boot_count    <= 4'd0;
      instr_o       <= 9'h000;
      instr_pc_o    <= 8'h00;
      instr_valid_o <= 1'b0;
      halted_o      <= 1'b0;
    end else begin
      state         <= next_state;
      boot_count    <= next_boot_count;
      instr_o       <= next_instr;
      instr_pc_o    <= next_instr_pc;
      instr_valid_o <= next_valid;
      halted_o      <= next_halted;
    end
  end

  sat_counter16 u_stall_counter (
    .clock  (clock),
    .reset  (reset_i),
    .enable (stall_event),
    .count  (stall_count_o)
  );

  sat_counter16 u_squash_counter (
    .clock  (clock),
    .reset  (reset_i),
    .enable (squash_event),
    .count  (squash_count_o)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a reference model predicts the
// combinational PC controls each cycle and queues the registered outputs
// expected after the next edge.
module tb_fetch_sequencer;

  localparam logic [8:0] HALT_OP     = 9'h1FF;
  localparam int         BOOT_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset_i;
  logic [7:0]  pc_i;
  logic [8:0]  instr_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [7:0]  branch_target_i;
  logic [7:0]  newpc_o;
  logic        pc_wenable_o;
  logic        flush_o;
  logic [8:0]  instr_o;
  logic [7:0]  instr_pc_o;
  logic        instr_valid_o;
  logic        halted_o;
  logic [15:0] stall_count_o;
  logic [15:0] squash_count_o;

  fetch_sequencer #(.HALT_OP(HALT_OP), .BOOT_CYCLES(BOOT_CYCLES)) dut (
    .clock           (clock),
    .reset_i         (reset_i),
    .pc_i            (pc_i),
    .instr_i         (instr_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .newpc_o         (newpc_o),
    .pc_wenable_o    (pc_wenable_o),
    .flush_o         (flush_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_valid_o   (instr_valid_o),
    .halted_o        (halted_o),
    .stall_count_o   (stall_count_o),
    .squash_count_o  (squash_count_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0]  instr;
    logic [7:0]  ipc;
    logic        valid;
    logic        halted;
    logic [15:0] stalls;
    logic [15:0] squashes;
  } regs_t;

  regs_t      sb_q[$];
  logic [8:0] rom [256];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Model state: 0 boot, 1 run, 2 halt.
  int         m_state;
  int         m_boot;
  regs_t      m;
  logic [7:0] pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_state = 0;
    m_boot  = 0;
    m       = '0;
    pc      = 8'h00;
  endtask

  // One clock cycle: drive, check PC controls, predict, clock, check IF/ID.
  task automatic cycle(input logic st, input logic br, input logic [7:0] tgt);
    logic       e_wen, e_flush;
    logic [7:0] e_val, e_newpc;
    int         n_state;
    regs_t      n, got;
    e_wen = 1'b0; e_flush = 1'b0; e_val = pc; n = m; n_state = m_state;
    case (m_state)
      0: begin
        n.valid = 1'b0;
        if (m_boot == BOOT_CYCLES - 1) begin n_state = 1; m_boot = 0; end
        else m_boot = m_boot + 1;
      end
      1: begin
        if (br) begin
          e_wen = 1'b1; e_flush = 1'b1; e_val = tgt; n.valid = 1'b0;
          if (n.squashes != 16'hFFFF) n.squashes = n.squashes + 16'd1;
        end else if (st) begin
          if (n.stalls != 16'hFFFF) n.stalls = n.stalls + 16'd1;
        end else begin
          n.instr = rom[pc]; n.ipc = pc; n.valid = 1'b1;
          if (rom[pc] == HALT_OP) begin n_state = 2; n.halted = 1'b1; end
          else begin e_wen = 1'b1; e_val = pc + 8'd1; end
        end
      end
      default: begin
        if (br) begin
          e_wen = 1'b1; e_flush = 1'b1; e_val = tgt; n.valid = 1'b0;
          n_state = 1; n.halted = 1'b0;
          if (n.squashes != 16'hFFFF) n.squashes = n.squashes + 16'd1;
        end else if (!st) begin
          n.valid = 1'b0;
        end
      end
    endcase
    e_newpc = e_wen ? e_val : pc;
    pc_i = pc; instr_i = rom[pc]; stall_i = st;
    branch_taken_i = br; branch_target_i = tgt;
    #1;
    check("pc_wenable", 32'(pc_wenable_o), 32'(e_wen));
    check("newpc", 32'(newpc_o), 32'(e_newpc));
    check("flush", 32'(flush_o), 32'(e_flush));
    sb_q.push_back(n);
    @(posedge clock);
    m = n; m_state = n_state;
    if (e_wen) pc = e_newpc;
    #1;
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      n = sb_q.pop_front();
      got = '{instr_o, instr_pc_o, instr_valid_o, halted_o, stall_count_o, squash_count_o};
      check("instr", 32'(got.instr), 32'(n.instr));
      check("instr_pc", 32'(got.ipc), 32'(n.ipc));
      check("instr_valid", 32'(got.valid), 32'(n.valid));
      check("halted", 32'(got.halted), 32'(n.halted));
      check("stall_count", 32'(got.stalls), 32'(n.stalls));
      check("squash_count", 32'(got.squashes), 32'(n.squashes));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, "_halted"}, 32'(halted_o), 32'd0);
    check({tag, "_instr"}, 32'(instr_o), 32'd0);
    check({tag, "_ipc"}, 32'(instr_pc_o), 32'd0);
    check({tag, "_stalls"}, 32'(stall_count_o), 32'd0);
    check({tag, "_squashes"}, 32'(squash_count_o), 32'd0);
    check({tag, "_wen"}, 32'(pc_wenable_o), 32'd0);
    check({tag, "_newpc"}, 32'(newpc_o), 32'd0);
    check({tag, "_flush"}, 32'(flush_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'(i);
    rom[8'h10] = HALT_OP;
    model_reset();
    reset_i = 1'b1; pc_i = 8'h33; instr_i = 9'h033; stall_i = 1'b1;
    branch_taken_i = 1'b1; branch_target_i = 8'h44;
    @(posedge clock); #1;
    check_cleared("reset");
    reset_i = 1'b0;

    // Boot then sequential fetch 0..4, branch/stall ignored in boot.
    cycle(1'b1, 1'b1, 8'h55);
    cycle(1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);
    // Three stall cycles at pc 5, then resume.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    // Branch beats stall at pc 7.
    cycle(1'b1, 1'b1, 8'h20);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    // Wrap at 8'hFF.
    cycle(1'b0, 1'b1, 8'hFF);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    // Halt at 8'h10, sit halted (one stalled cycle), then restart.
    cycle(1'b0, 1'b1, 8'h0F);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h30);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Asynchronous reset pulse between edges while running.
    pc_i = 8'h32; instr_i = rom[8'h32]; stall_i = 1'b0; branch_taken_i = 1'b1;
    branch_target_i = 8'h77;
    #1;
    reset_i = 1'b1;
    #1;
    check_cleared("async_reset");
    reset_i = 1'b0;
    model_reset();
    // Back through boot and fetching from zero.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
